// File: rtl/shift_pipe_pkg.sv
// Shared shift-mode encodings and per-stage control payload for the pipelined shifter.
// The mode type is also used by the instruction decoder.
package shift_pipe_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_mode_t;

    // Control that travels with the data between register stages
    typedef struct packed {
        shift_mode_t mode;
        logic        sign;
    } shift_ctl_t;

endpackage

// File: rtl/shift_level.sv
// One binary-weighted mux level of the barrel shifter: shifts by 2^LEVEL when en is set.
// Purely combinational; the fill bit is only consulted for arithmetic right shifts.
module shift_level
    import shift_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEVEL = 0
) (
    input  logic [WIDTH-1:0] d,
    input  shift_mode_t      mode,
    input  logic             fill,
    input  logic             en,
    output logic [WIDTH-1:0] q_c
);

    localparam int unsigned AMT = 32'(1) << LEVEL;

    always_comb begin
        q_c = d;
        if (en) begin
            case (mode)
                SHIFT_SLL: q_c = {d[WIDTH-AMT-1:0], {AMT{1'b0}}};
                SHIFT_SRL: q_c = {{AMT{1'b0}}, d[WIDTH-1:AMT]};
                SHIFT_SRA: q_c = {{AMT{fill}}, d[WIDTH-1:AMT]};
                SHIFT_ROL: q_c = {d[WIDTH-AMT-1:0], d[WIDTH-1:WIDTH-AMT]};
                default:   q_c = d;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides and a sideband tag.
// Mux levels are spread evenly over STAGES register stages; empty stages collapse under stall.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         x,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [1:0]               mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         z,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LPS    = (LEVELS + STAGES - 1) / STAGES;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] load_c;
    logic [STAGES-1:0] vin_c;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  din_c  [STAGES];
    logic [WIDTH-1:0]  dout_c [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tin_c  [STAGES];

    // A stage loads unless it and every stage after it are full and the consumer stalls
    always_comb begin
        load_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            load_c[k] = out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!vld_q[j]) begin
                    load_c[k] = 1'b1;
                end
            end
        end
    end

    // Stage inputs: the ports feed stage 0, each register feeds the next stage
    always_comb begin
        vin_c    = STAGES'({vld_q, in_valid});
        din_c[0] = x;
        tin_c[0] = in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            din_c[k] = data_q[k-1];
            tin_c[k] = tag_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * LPS;
        localparam int unsigned HI = ((k + 1) * LPS < LEVELS) ? (k + 1) * LPS : LEVELS;
        localparam int unsigned NL = (HI > LO) ? HI - LO : 0;

        if (NL == 0) begin : g_pass
            assign dout_c[k] = din_c[k];
        end else begin : g_lv
            shift_mode_t             m_in;
            logic                    s_in;
            logic [LEVELS-LO-1:0]    a_in;
            logic [WIDTH-1:0]        chain [NL+1];

            if (k == 0) begin : g_src
                assign m_in = shift_mode_t'(mode);
                assign s_in = x[WIDTH-1];
                assign a_in = shamt;
            end else begin : g_src
                assign m_in = g_stage[k-1].g_lv.g_ctl.ctl_q.mode;
                assign s_in = g_stage[k-1].g_lv.g_ctl.ctl_q.sign;
                assign a_in = g_stage[k-1].g_lv.g_ctl.amt_q;
            end

            assign chain[0] = din_c[k];
            for (genvar j = 0; j < NL; j++) begin : g_level
                shift_level #(
                    .WIDTH(WIDTH),
                    .LEVEL(LO + j)
                ) u_level (
                    .d   (chain[j]),
                    .mode(m_in),
                    .fill(s_in),
                    .en  (a_in[j]),
                    .q_c (chain[j+1])
                );
            end
            assign dout_c[k] = chain[NL];

            // Only stages with levels still ahead carry mode, sign and the unused shamt bits
            if (k < STAGES - 1 && HI < LEVELS) begin : g_ctl
                shift_ctl_t            ctl_q;
                logic [LEVELS-HI-1:0]  amt_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ctl_q <= '0;
                        amt_q <= '0;
                    end else if (load_c[k] && vin_c[k]) begin
                        ctl_q.mode <= m_in;
                        ctl_q.sign <= s_in;
                        amt_q      <= a_in[LEVELS-LO-1:NL];
                    end
                end
            end
        end
    end

    // Stage registers; data and tag only move with a valid operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load_c[k]) begin
                    vld_q[k] <= vin_c[k];
                    if (vin_c[k]) begin
                        data_q[k] <= dout_c[k];
                        tag_q[k]  <= tin_c[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load_c[0];
    assign out_valid = vld_q[STAGES-1];
    assign z         = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, streaming/stall/bubble/reset sequences,
// and randomized traffic on several WIDTH/STAGES configurations against a reference model.
module tb_shift_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=32 STAGES=2
    logic iv0, or0, ir0, ov0;
    logic [31:0] x0, z0;
    logic [4:0] sh0, tg0, ot0;
    logic [1:0] md0;
    // Instance 1: WIDTH=32 STAGES=3
    logic iv1, or1, ir1, ov1;
    logic [31:0] x1, z1;
    logic [4:0] sh1, tg1, ot1;
    logic [1:0] md1;
    // Instance 2: WIDTH=8 STAGES=1
    logic iv2, or2, ir2, ov2;
    logic [7:0] x2, z2;
    logic [2:0] sh2;
    logic [4:0] tg2, ot2;
    logic [1:0] md2;
    // Instance 3: WIDTH=64 STAGES=6
    logic iv3, or3, ir3, ov3;
    logic [63:0] x3, z3;
    logic [5:0] sh3;
    logic [4:0] tg3, ot3;
    logic [1:0] md3;

    shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x(x0), .shamt(sh0),
        .mode(md0), .in_tag(tg0), .out_valid(ov0), .out_ready(or0), .z(z0), .out_tag(ot0));
    shift_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x(x1), .shamt(sh1),
        .mode(md1), .in_tag(tg1), .out_valid(ov1), .out_ready(or1), .z(z1), .out_tag(ot1));
    shift_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .x(x2), .shamt(sh2),
        .mode(md2), .in_tag(tg2), .out_valid(ov2), .out_ready(or2), .z(z2), .out_tag(ot2));
    shift_pipe #(.WIDTH(64), .STAGES(6), .TAG_W(5)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .x(x3), .shamt(sh3),
        .mode(md3), .in_tag(tg3), .out_valid(ov3), .out_ready(or3), .z(z3), .out_tag(ot3));

    typedef struct {
        logic [63:0] z;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        int          s;
        int          m;
        int          t;
        logic [31:0] z;
    } vec_t;

    exp_t sbq [4][$];
    int nerr = 0;
    int nchk = 0;
    logic        cur_ir, cur_ov;
    logic [63:0] cur_z;
    logic [4:0]  cur_tag;

    function automatic int wd_of(int sel);
        case (sel)
            0, 1:    return 32;
            2:       return 8;
            default: return 64;
        endcase
    endfunction

    // Reference: shift rules on a w-bit value held in a 64-bit variable
    function automatic logic [63:0] ref_shift(logic [63:0] a, int s, int m, int w);
        logic [63:0] mask, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a & mask;
        case (m)
            0: r = (a << s) & mask;
            1: r = a >> s;
            2: begin
                r = a >> s;
                if (a[w-1]) r = r | (mask & ~(mask >> s));
            end
            default: r = ((a << s) | (a >> (w - s))) & mask;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample just after, scoreboard both transfers
    task automatic cycle(input int sel, input bit v, input logic [63:0] xx, input int s,
                         input int m, input int t, input bit r);
        exp_t e;
        @(negedge clk);
        case (sel)
            0: begin iv0 = v; x0 = 32'(xx); sh0 = 5'(s); md0 = 2'(m); tg0 = 5'(t); or0 = r; end
            1: begin iv1 = v; x1 = 32'(xx); sh1 = 5'(s); md1 = 2'(m); tg1 = 5'(t); or1 = r; end
            2: begin iv2 = v; x2 = 8'(xx);  sh2 = 3'(s); md2 = 2'(m); tg2 = 5'(t); or2 = r; end
            default: begin iv3 = v; x3 = xx; sh3 = 6'(s); md3 = 2'(m); tg3 = 5'(t); or3 = r; end
        endcase
        #1;
        case (sel)
            0: begin cur_ir = ir0; cur_ov = ov0; cur_z = 64'(z0); cur_tag = ot0; end
            1: begin cur_ir = ir1; cur_ov = ov1; cur_z = 64'(z1); cur_tag = ot1; end
            2: begin cur_ir = ir2; cur_ov = ov2; cur_z = 64'(z2); cur_tag = ot2; end
            default: begin cur_ir = ir3; cur_ov = ov3; cur_z = z3; cur_tag = ot3; end
        endcase
        if (cur_ov && r) begin
            if (sbq[sel].size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: got z=%h tag=%0d expected no result", cur_z, cur_tag);
            end else begin
                e = sbq[sel].pop_front();
                chk("sb_z", cur_z, e.z);
                chk("sb_tag", 64'(cur_tag), 64'(e.tag));
            end
        end
        if (v && cur_ir) begin
            e.z   = ref_shift(xx, s, m, wd_of(sel));
            e.tag = 5'(t);
            sbq[sel].push_back(e);
        end
    endtask

    task automatic run_random(input int sel, input int nops, input int budget);
        int acc = 0;
        int cyc = 0;
        bit v, r;
        while (acc < nops && cyc < budget) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(sel, v, {$urandom(), $urandom()}, $urandom_range(0, wd_of(sel) - 1),
                  $urandom_range(0, 3), $urandom_range(0, 31), r);
            if (v && cur_ir) acc++;
            cyc++;
        end
        chk("rand_accepted", 64'(acc), 64'(nops));
        cyc = 0;
        while (sbq[sel].size() != 0 && cyc < 64) begin
            cycle(sel, 0, 64'd0, 0, 0, 0, 1);
            cyc++;
        end
        chk("rand_drain", 64'(sbq[sel].size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [13];
        int          lat;
        bit          found;
        logic [63:0] xs, exp0;

        tbl[0]  = '{32'h000000ab, 3,  0, 1,  32'h00000558};
        tbl[1]  = '{32'h800000ab, 3,  2, 2,  32'hf0000015};
        tbl[2]  = '{32'h800000ab, 3,  1, 3,  32'h10000015};
        tbl[3]  = '{32'h80000d2c, 8,  3, 4,  32'h000d2c80};
        tbl[4]  = '{32'h80000d2c, 9,  1, 5,  32'h00400006};
        tbl[5]  = '{32'hdeadbeef, 0,  0, 6,  32'hdeadbeef};
        tbl[6]  = '{32'hdeadbeef, 0,  1, 7,  32'hdeadbeef};
        tbl[7]  = '{32'hdeadbeef, 0,  2, 8,  32'hdeadbeef};
        tbl[8]  = '{32'hdeadbeef, 0,  3, 9,  32'hdeadbeef};
        tbl[9]  = '{32'h00000001, 31, 0, 10, 32'h80000000};
        tbl[10] = '{32'h80000000, 31, 2, 11, 32'hffffffff};
        tbl[11] = '{32'h80000001, 31, 3, 12, 32'hc0000000};
        tbl[12] = '{32'h7fffffff, 4,  2, 13, 32'h07ffffff};

        {iv0, iv1, iv2, iv3} = '0;
        {or0, or1, or2, or3} = '1;
        {x0, x1, x2, x3} = '0;
        {sh0, sh1, sh2, sh3} = '0;
        {md0, md1, md2, md3} = '0;
        {tg0, tg1, tg2, tg3} = '0;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_ov0", 64'(ov0), 64'd0);
        chk("reset_z0", 64'(z0), 64'd0);
        chk("reset_ov3", 64'(ov3), 64'd0);
        chk("reset_z3", z3, 64'd0);
        rst_n = 1'b1;

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 13; i++) begin
            cycle(0, 1, 64'(tbl[i].x), tbl[i].s, tbl[i].m, tbl[i].t, 1);
            chk("dir_accept", 64'(cur_ir), 64'd1);
            lat = 0;
            found = 0;
            for (int k = 1; k <= 10 && !found; k++) begin
                cycle(0, 0, 64'd0, 0, 0, 0, 1);
                if (cur_ov) begin
                    found = 1;
                    lat = k;
                end
            end
            chk("dir_latency", 64'(lat), 64'd2);
            chk("dir_z", cur_z, 64'(tbl[i].z));
            chk("dir_tag", 64'(cur_tag), 64'(tbl[i].t));
        end

        // Back-to-back stream of 8: results on 8 consecutive cycles
        for (int i = 0; i < 10; i++) begin
            cycle(0, i < 8, 64'($urandom()), $urandom_range(0, 31), $urandom_range(0, 3), i, 1);
            if (i >= 2) chk("stream_ov", 64'(cur_ov), 64'd1);
        end
        cycle(0, 0, 64'd0, 0, 0, 0, 1);
        chk("stream_done", 64'(cur_ov), 64'd0);

        // Output stall for 5 cycles with input pressure
        xs = 64'($urandom());
        exp0 = ref_shift(xs, 5, 3, 32);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) cycle(0, 1, xs, 5, 3, 20, 0);
            else cycle(0, 1, 64'($urandom()), $urandom_range(0, 31), $urandom_range(0, 3), 20 + i, 0);
            if (i < 2) chk("stall_ir_fill", 64'(cur_ir), 64'd1);
            else begin
                chk("stall_ir", 64'(cur_ir), 64'd0);
                chk("stall_z", cur_z, exp0);
                chk("stall_tag", 64'(cur_tag), 64'd20);
            end
        end
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 64'($urandom()), $urandom_range(0, 31), $urandom_range(0, 3), 26 + i, 1);
        for (int i = 0; i < 10 && sbq[0].size() != 0; i++) cycle(0, 0, 64'd0, 0, 0, 0, 1);
        chk("stall_drain", 64'(sbq[0].size()), 64'd0);

        // Bubble collapse on the 3-stage pipe
        cycle(1, 1, 64'h0000_1111, 1, 0, 1, 0);
        chk("bubble_acc_a", 64'(cur_ir), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 64'd0, 0, 0, 0, 0);
        chk("bubble_stalled", 64'(cur_ov), 64'd1);
        cycle(1, 1, 64'h0000_2222, 2, 1, 2, 0);
        chk("bubble_ir_b", 64'(cur_ir), 64'd1);
        cycle(1, 1, 64'h8000_3333, 3, 2, 3, 0);
        chk("bubble_ir_c", 64'(cur_ir), 64'd1);
        cycle(1, 1, 64'h0000_4444, 4, 3, 4, 0);
        chk("bubble_ir_full", 64'(cur_ir), 64'd0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 64'd0, 0, 0, 0, 1);
        chk("bubble_drain", 64'(sbq[1].size()), 64'd0);

        // Asynchronous reset with two operations in flight
        cycle(0, 1, 64'h0000_1234, 4, 0, 5, 1);
        cycle(0, 1, 64'h0000_5678, 4, 0, 6, 1);
        @(posedge clk);
        #2;
        chk("pre_reset_ov", 64'(ov0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ov", 64'(ov0), 64'd0);
        chk("async_rst_z", 64'(z0), 64'd0);
        iv0 = 1'b0;
        for (int i = 0; i < 4; i++) sbq[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 64'd0, 0, 0, 0, 1);
            chk("no_stale", 64'(cur_ov), 64'd0);
        end

        // Randomized traffic against the reference model
        run_random(0, 300, 3000);
        run_random(2, 1000, 8000);
        run_random(3, 1000, 8000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the CPU execute stage, replacing the fixed 32-bit combinational left shifter.
- Supports four modes: logical left, logical right, arithmetic right and rotate left.
- Shifts any power-of-two width across a configurable number of register stages, with valid/ready handshakes on both sides.
- Carries a tag (e.g. destination register number) alongside each operation so results can be written back out of band.

Parameters:
- WIDTH, 32, data width in bits; power of two, at least 2.
- STAGES, 2, pipeline register stages (latency); 1 to log2(WIDTH).
- TAG_W, 5, width of the sideband tag carried with each operation.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an operation is presented on x/shamt/mode/in_tag.
- in_ready  output  1  the pipe accepts the operation this cycle.
- x  input  WIDTH  operand.
- shamt  input  log2(WIDTH)  shift amount, unsigned.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  z/out_tag hold a result.
- out_ready  input  1  the consumer takes the result this cycle.
- z  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result on z.

Behaviour:
- Reset: one clock, asynchronous, active-low. While rst_n=0, every stage valid bit, out_valid, z and out_tag are 0, and any in-flight operations are discarded. After release, the first transfer can occur on the next rising edge.
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both 1.
  - Output transfer occurs when out_valid and out_ready are both 1.
- Mux levels: LEVELS = log2(WIDTH), one binary-weighted level per shamt bit, LSB first. Stage k (0-based) performs levels k*P to min((k+1)*P, LEVELS)-1, where P = ceil(LEVELS/STAGES). The last stage's register drives z directly.
- Latency: exactly STAGES cycles from input transfer to out_valid when the pipe is not stalled.
- Throughput: one operation per cycle.
- Per-stage advance rule: stage k loads when it is empty or when stage k+1 (or the consumer, for the last stage) accepts this cycle. in_ready equals stage 0's load condition. Bubbles collapse, so a stalled output never blocks an empty upstream stage.
- Stall: when out_valid=1 and out_ready=0, z and out_tag hold stable and no data is lost.
- Arithmetic rules:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with x[WIDTH-1], the sign bit sampled at input.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - shamt = 0 returns x unchanged in every mode.
  - Maximum shift is WIDTH-1; there are no out-of-range amounts.
- Mode and sign bit travel with the data through the stages; no global state.
- Simultaneous input and output transfer on a full pipe is legal and sustains full rate.
- Synthesisable, with no combinational path from in_valid to out_valid. The only combinational backpressure path runs from out_ready to in_ready.

Decomposition:
- Shared package: mode encodings (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROL=2'b11) and the 2-bit shift_mode type, shared with the decoder.
- One sub-module, shift_level: a single combinational mux level parametrised by WIDTH and level index (shift amount 2^i). It takes data, mode, fill bit and enable, and returns the level output.
- shift_pipe instantiates LEVELS shift_level instances and the STAGES registers with their valid bits.

Test Plan:
- SLL: x=32'h000000ab, shamt=3, tag=1 -> z=32'h00000558, out_tag=1, out_valid exactly STAGES cycles after acceptance.
- SRA: x=32'h800000ab, shamt=3 -> z=32'hf0000015. Same x in SRL -> z=32'h10000015.
- ROL: x=32'h80000d2c, shamt=8 -> z=32'h000d2c80. SRL of the same x with shamt=9 -> z=32'h00400006. shamt=0 in all four modes -> z=x.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order, with matching tags. Then hold out_ready=0 for 5 cycles -> in_ready drops once the pipe is full, z is stable, and after release no op is lost or duplicated.
- Bubble collapse (STAGES=3): one op stalled at the output with an empty middle stage -> in_ready stays 1 until all 3 stages are occupied.
- Reset mid-operation: assert rst_n=0 asynchronously between edges with 2 ops in flight -> out_valid=0 and z=0 immediately, and no stale result appears after release. Sweep WIDTH=8/STAGES=1 and WIDTH=64/STAGES=6 against a reference model on 1000 random ops.
